issue_fifo: RTL and testbench
=============================

ISSUE_FIFO -- requirements
Module: issue_fifo

Interface
REQ-001 Parameter DATA_W, default 64: width of the opaque decoded-instruction payload.
REQ-002 Parameter DEPTH, default 4: number of entries; power of two, >= 2.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  discard all buffered entries (controller flush / flush_unissued).
REQ-006 in_valid_i  input  1  decoder presents an instruction.
REQ-007 in_ready_o  output  1  buffer accepts the presented instruction this cycle.
REQ-008 in_data_i  input  DATA_W  decoded-instruction payload.
REQ-009 in_macro_i  input  1  instruction is part of a fused macro pair.
REQ-010 in_macro_last_i  input  1  instruction is the second (last) half of a macro pair.
REQ-011 out_valid_o  output  1  head entry offered to scoreboard issue port.
REQ-012 out_ack_i  input  1  scoreboard consumed the head entry.
REQ-013 out_data_o  output  DATA_W  head payload.
REQ-014 out_macro_o  output  1  head macro flag.
REQ-015 out_macro_last_o  output  1  head macro-last flag.
REQ-016 count_o  output  $clog2(DEPTH)+1  number of valid entries.
REQ-017 full_o  output  1  count_o == DEPTH (perf counter).

Function
REQ-018 Storage SHALL be DEPTH registered entries {data, macro, macro_last} with read pointer, write pointer (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and a count register.
REQ-019 in_ready_o SHALL equal (count < DEPTH); no combinational path from out_ack_i to in_ready_o.
REQ-020 Push occurs when in_valid_i && in_ready_o && !flush_i: entry written at write pointer, write pointer +1.
REQ-021 Pop occurs when out_ack_i && out_valid_o && !flush_i: read pointer +1.
REQ-022 count_next = count + push - pop; push and pop in the same cycle leave count unchanged.
REQ-023 Latency: an entry pushed in cycle N SHALL be visible at the outputs no earlier than cycle N+1 (no bypass).
REQ-024 out_data_o, out_macro_o, out_macro_last_o SHALL be driven from the entry at the read pointer regardless of out_valid_o.
REQ-025 Pair atomicity: out_valid_o = (count >= 1) && !(head.macro && !head.macro_last && count < 2).
REQ-026 A first-half macro entry SHALL therefore be withheld until its second half is buffered; in_ready_o is unaffected.
REQ-027 out_ack_i while out_valid_o = 0 SHALL be ignored.
REQ-028 flush_i SHALL, on the next edge, set count, read pointer and write pointer to 0; push and pop in the flush cycle are discarded.
REQ-029 Payload contents are not cleared by flush or reset-only control state is.
REQ-030 full_o SHALL equal (count == DEPTH); empty state implies out_valid_o = 0.

Reset
REQ-031 On rst_ni low, asynchronously: count = 0, read and write pointers = 0, payload storage = 0.
REQ-032 Outputs during and after reset until first push: in_ready_o = 1, out_valid_o = 0, out_data_o = 0, out_macro_o = 0, out_macro_last_o = 0, count_o = 0, full_o = 0.
REQ-033 Reset asserted mid-operation SHALL drop all entries; no partial pair survives.

Verification
REQ-034 Fill/drain: push A,B,C,D (DEPTH=4) with out_ack_i=0 -> count_o=4, full_o=1, in_ready_o=0; then ack 4 cycles -> out_data_o sequence A,B,C,D, count_o=0.
REQ-035 Simultaneous push/pop at count=2 -> count_o stays 2, order preserved, pointer wrap after 5+ pushes verified.
REQ-036 Macro pair: push X(macro=1,last=0) alone -> out_valid_o=0 for 3 cycles; push Y(macro=1,last=1) -> out_valid_o=1 next cycle, X then Y issued on consecutive acks.
REQ-037 Flush: count=3, assert flush_i with in_valid_i=1 and out_ack_i=1 -> next cycle count_o=0, out_valid_o=0, pushed entry not later observed.
REQ-038 Reset mid-operation: count=2 with pending macro half, pulse rst_ni low asynchronously -> count_o=0, out_valid_o=0, in_ready_o=1 immediately.
REQ-039 Spurious ack: out_ack_i=1 with empty buffer -> count_o remains 0, pointers unchanged.

Source files
------------

// File: rtl/issue_fifo.sv
// Issue buffer between decode and scoreboard: DEPTH-entry FIFO, one cycle push-to-issue latency, no bypass.
// Backpressure: in_ready_o depends only on occupancy; a macro first half is held back until its partner is buffered.
module issue_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [DATA_W-1:0]        in_data_i,
   input  logic                     in_macro_i,
   input  logic                     in_macro_last_i,
   output logic                     out_valid_o,
   input  logic                     out_ack_i,
   output logic [DATA_W-1:0]        out_data_o,
   output logic                     out_macro_o,
   output logic                     out_macro_last_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  macro_q;
   logic [DEPTH-1:0]  last_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [PW-1:0]     wr_ptr_q;
   logic [CW-1:0]     count_q;
   logic              push;
   logic              pop;
   logic              head_pair_open;

   assign in_ready_o       = (count_q < DEPTH_C);
   assign full_o           = (count_q == DEPTH_C);
   assign count_o          = count_q;
   assign out_data_o       = data_q[rd_ptr_q];
   assign out_macro_o      = macro_q[rd_ptr_q];
   assign out_macro_last_o = last_q[rd_ptr_q];

   // A lone first half must not issue; its partner may still be in decode.
   assign head_pair_open = macro_q[rd_ptr_q] && !last_q[rd_ptr_q];
   assign out_valid_o    = (count_q != '0) && !(head_pair_open && (count_q < CW'(2)));

   assign push = in_valid_i && in_ready_o && !flush_i;
   assign pop  = out_ack_i && out_valid_o && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Payload is only cleared by reset; flush just rewinds the control state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
         end
         macro_q <= '0;
         last_q  <= '0;
      end else if (push) begin
         data_q[wr_ptr_q]  <= in_data_i;
         macro_q[wr_ptr_q] <= in_macro_i;
         last_q[wr_ptr_q]  <= in_macro_last_i;
      end
   end

endmodule

// File: tb/tb_issue_fifo.sv
// Directed bench for issue_fifo with a queue-based reference model checked every cycle.
module tb_issue_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_macro;
   logic        in_last;
   logic        out_valid;
   logic        out_ack;
   logic [63:0] out_data;
   logic        out_macro;
   logic        out_last;
   logic [2:0]  count;
   logic        full;

   int passes = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic [63:0] d;
      logic        m;
      logic        l;
   } ent_t;

   ent_t q[$];

   always #5 clk = ~clk;

   issue_fifo #(.DATA_W(64), .DEPTH(4)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .flush_i          (flush),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_data_i        (in_data),
      .in_macro_i       (in_macro),
      .in_macro_last_i  (in_last),
      .out_valid_o      (out_valid),
      .out_ack_i        (out_ack),
      .out_data_o       (out_data),
      .out_macro_o      (out_macro),
      .out_macro_last_o (out_last),
      .count_o          (count),
      .full_o           (full)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_valid();
      if (q.size() == 0) return 1'b0;
      return !(q[0].m && !q[0].l && q.size() < 2);
   endfunction

   // Reference model: FIFO order, occupancy limit 4, pair withholding, flush/reset empty it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         bit psh;
         bit pp;
         ent_t e;
         psh = in_valid && (q.size() < 4);
         pp  = out_ack && m_valid();
         e   = '{d: in_data, m: in_macro, l: in_last};
         if (pp) void'(q.pop_front());
         if (psh) q.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_count", 64'(count), 64'(q.size()));
         check("cmp_full", 64'(full), 64'(q.size() == 4));
         check("cmp_ready", 64'(in_ready), 64'(q.size() < 4));
         check("cmp_valid", 64'(out_valid), 64'(m_valid()));
         if (q.size() > 0) begin
            check("cmp_data", out_data, q[0].d);
            check("cmp_macro", 64'(out_macro), 64'(q[0].m));
            check("cmp_last", 64'(out_last), 64'(q[0].l));
         end
      end
   end

   task automatic cyc(input logic v, input logic [63:0] d, input logic m, input logic l,
                      input logic a, input logic f);
      in_valid = v; in_data = d; in_macro = m; in_last = l; out_ack = a; flush = f;
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ack = 1'b0; flush = 1'b0;
   endtask

   task automatic push(input logic [63:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_macro = 1'b0; in_last = 1'b0; out_ack = 1'b0;
      #12;
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_data", out_data, 64'd0);
      check("post_rst_macro", 64'(out_macro), 64'd0);
      check("post_rst_last", 64'(out_last), 64'd0);
      check("post_rst_full", 64'(full), 64'd0);
      chk_en = 1'b1;

      // spurious ack on empty buffer
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("spur_count", 64'(count), 64'd0);
      check("spur_valid", 64'(out_valid), 64'd0);

      // fill to full, attempt overflow, then drain
      for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
      check("fill_count", 64'(count), 64'd4);
      check("fill_full", 64'(full), 64'd1);
      check("fill_ready", 64'(in_ready), 64'd0);
      push(64'hEE);
      check("overflow_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check("drain_head", out_data, 64'hA0 + 64'(i));
         cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("drain_count", 64'(count), 64'd0);

      // simultaneous push/pop at count 2, wrapping the pointers
      push(64'hB0);
      push(64'hB1);
      for (int i = 0; i < 5; i++) begin
         check("wrap_head", out_data, 64'hB0 + 64'(i));
         cyc(1'b1, 64'hB2 + 64'(i), 1'b0, 1'b0, 1'b1, 1'b0);
         check("wrap_count", 64'(count), 64'd2);
      end
      for (int i = 5; i < 7; i++) begin
         check("wrap_tail", out_data, 64'hB0 + 64'(i));
         cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("wrap_empty", 64'(count), 64'd0);

      // macro pair: first half withheld until second half arrives
      cyc(1'b1, 64'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("pair_hold", 64'(out_valid), 64'd0);
         cyc(1'b0, 64'd0, 1'b0, 1'b0, (i == 1), 1'b0);
      end
      check("pair_hold_count", 64'(count), 64'd1);
      cyc(1'b1, 64'hC1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("pair_release", 64'(out_valid), 64'd1);
      check("pair_x", out_data, 64'hC0);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pair_y", out_data, 64'hC1);
      check("pair_y_last", 64'(out_last), 64'd1);
      check("pair_y_valid", 64'(out_valid), 64'd1);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pair_done", 64'(count), 64'd0);

      // flush with concurrent push and ack
      for (int i = 0; i < 3; i++) push(64'hD0 + 64'(i));
      check("pre_flush_count", 64'(count), 64'd3);
      cyc(1'b1, 64'hD3, 1'b0, 1'b0, 1'b1, 1'b1);
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      push(64'hE0);
      check("post_flush_head", out_data, 64'hE0);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("post_flush_empty", 64'(count), 64'd0);

      // asynchronous reset with a pending macro half
      push(64'hF0);
      cyc(1'b1, 64'hF1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("pre_rst_count", 64'(count), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count", 64'(count), 64'd0);
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_ready", 64'(in_ready), 64'd1);
      check("arst_data", out_data, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(64'h77);
      check("post_arst_head", out_data, 64'h77);
      check("post_arst_macro", 64'(out_macro), 64'd0);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("post_arst_empty", 64'(count), 64'd0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
